// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity-mode constants.
// Intended to be shared by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake between a data source (master) and the UART transmitter (slave).
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/baud_edge_det.sv
// Rising-edge detector for the baud level; emits a one-cycle bit_tick per baud period.
module baud_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_clk,
  output logic bit_tick
);

  logic baud_q;

  // Resetting high keeps a baud level that is already high at release from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_q <= 1'b1;
    else        baud_q <= baud_clk;
  end

  assign bit_tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// one bit per baud tick with a registered, idle-high serial output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_clk,
  uart_tx_if.slave   tx_if,
  output logic       busy,
  output logic       tx
);

  localparam int   CW      = $clog2(DATA_BITS);
  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_EN < 0 || PARITY_EN > 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $fatal(1, "uart_tx: illegal parameter value");
  end

  tx_state_t            state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 tx_d;
  logic                 bit_tick;

  baud_edge_det u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_clk (baud_clk),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      par_q    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      par_q    <= par_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      tx       <= tx_d;
    end
  end

  // Ticks are only honoured after accept, so the start bit is always a full period long.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    tx_d       = tx;
    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_if.tx_valid) begin
          shreg_d = tx_if.tx_data;
          par_d   = (^tx_if.tx_data) ^ PAR_SEL;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bit_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_d      = shreg[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == CW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            shreg_d   = shreg >> 1;
            tx_d      = shreg[1];
            bit_cnt_d = bit_cnt + CW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) state_d = IDLE;
          else                               stop_cnt_d = stop_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_if.tx_ready = (state == IDLE);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameter variants, directed frames plus random traffic,
// each frame compared clock-by-clock against a frame built from the framing rules.
module tb_uart_tx;

  localparam int NI = 4;
  localparam int DB [NI] = '{8, 8, 8, 5};
  localparam int PE [NI] = '{0, 1, 1, 1};
  localparam int PO [NI] = '{0, 0, 1, 1};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          baud_clk = 1'b1;
  logic          baud_run = 1'b0;
  logic          rose     = 1'b0;
  logic [1:0]    bc       = '0;
  logic [NI-1:0] valid    = '0;
  logic [NI-1:0] tx_o, busy_o, ready_o;
  logic [8:0]    data [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Baud source: toggles every 4 clocks; 'rose' is high in the cycle right after each rising edge.
  always @(posedge clk) begin
    if (!baud_run) begin
      bc       <= '0;
      baud_clk <= 1'b1;
      rose     <= 1'b0;
    end else begin
      rose <= 1'b0;
      if (bc == 2'd3) begin
        bc       <= '0;
        baud_clk <= ~baud_clk;
        rose     <= ~baud_clk;
      end else begin
        bc <= bc + 2'd1;
      end
    end
  end

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(5)) if3 ();

  assign if0.tx_valid = valid[0];
  assign if1.tx_valid = valid[1];
  assign if2.tx_valid = valid[2];
  assign if3.tx_valid = valid[3];
  assign if0.tx_data  = data[0][7:0];
  assign if1.tx_data  = data[1][7:0];
  assign if2.tx_data  = data[2][7:0];
  assign if3.tx_data  = data[3][4:0];
  assign ready_o[0]   = if0.tx_ready;
  assign ready_o[1]   = if1.tx_ready;
  assign ready_o[2]   = if2.tx_ready;
  assign ready_o[3]   = if3.tx_ready;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_if(if0), .busy(busy_o[0]), .tx(tx_o[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_if(if1), .busy(busy_o[1]), .tx(tx_o[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_if(if2), .busy(busy_o[2]), .tx(tx_o[2]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_5o2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_if(if3), .busy(busy_o[3]), .tx(tx_o[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for each bit period of one frame of instance n carrying d.
  function automatic int build_frame(input int n, input logic [8:0] d, output logic [15:0] f);
    int len;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    len  = 1;
    ones = 0;
    for (int i = 0; i < DB[n]; i++) begin
      f[len] = d[i];
      ones   = ones + int'(d[i]);
      len++;
    end
    if (PE[n] != 0) begin
      f[len] = ((ones + PO[n]) % 2) != 0;
      len++;
    end
    for (int i = 0; i < SB[n]; i++) begin
      f[len] = 1'b1;
      len++;
    end
    return len;
  endfunction

  // Called just after a negedge. Returns at the first negedge after the frame ends.
  task automatic run_frame(input int n, input logic [8:0] d, input bit hold, input bit pulse,
                           output int waits);
    logic [15:0] f;
    int          len;
    bit          ok;
    len      = build_frame(n, d, f);
    data[n]  = d;
    valid[n] = 1'b1;
    waits    = 0;
    ok       = 1'b0;
    while (waits < 40 && !ok) begin
      if (ready_o[n]) ok = 1'b1;
      else begin
        @(negedge clk);
        waits++;
      end
    end
    check_eq($sformatf("n%0d accept", n), 32'(ok), 1);
    if (!ok) begin
      valid[n] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid[n] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      check_eq($sformatf("n%0d sync_tx", n), 32'(tx_o[n]), 1);
      check_eq($sformatf("n%0d sync_busy", n), 32'(busy_o[n]), 1);
      check_eq($sformatf("n%0d sync_ready", n), 32'(ready_o[n]), 0);
      if (rose) ok = 1'b1;
      @(negedge clk);
    end
    check_eq($sformatf("n%0d start_tick", n), 32'(ok), 1);
    for (int k = 0; k < 8 * len; k++) begin
      check_eq($sformatf("n%0d bit%0d clk%0d", n, k / 8, k % 8), 32'(tx_o[n]), 32'(f[k / 8]));
      check_eq($sformatf("n%0d busy_in_frame", n), 32'(busy_o[n]), 1);
      check_eq($sformatf("n%0d ready_in_frame", n), 32'(ready_o[n]), 0);
      if (pulse && k == 20) valid[n] = 1'b1;
      if (pulse && k == 21) valid[n] = 1'b0;
      @(negedge clk);
    end
    if (!hold) begin
      check_eq($sformatf("n%0d end_busy", n), 32'(busy_o[n]), 0);
      check_eq($sformatf("n%0d end_ready", n), 32'(ready_o[n]), 1);
      check_eq($sformatf("n%0d end_tx", n), 32'(tx_o[n]), 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          n;
    logic [8:0]  d;
    bit          ok;

    for (int i = 0; i < NI; i++) data[i] = '0;

    // Reset with the baud level held high
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_tx", 32'(tx_o), 32'hF);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    check_eq("rst_ready", 32'(ready_o), 32'hF);
    rst_n    = 1'b1;
    baud_run = 1'b1;
    @(negedge clk);
    check_eq("tick_at_release", 32'(u_8n1.bit_tick), 0);
    check_eq("release_tx", 32'(tx_o), 32'hF);
    check_eq("release_ready", 32'(ready_o), 32'hF);

    run_frame(0, 9'h0A5, 1'b0, 1'b0, w);
    run_frame(1, 9'h007, 1'b0, 1'b0, w);
    run_frame(2, 9'h007, 1'b0, 1'b0, w);

    // Back-to-back with tx_valid held: ready must be up on the very first idle cycle
    run_frame(0, 9'h055, 1'b1, 1'b0, w);
    run_frame(0, 9'h0AA, 1'b0, 1'b0, w);
    check_eq("b2b_ready_wait", 32'(w), 0);

    // Mid-frame pulse on the two-stop-bit variant must not start a second frame
    run_frame(3, 9'($urandom), 1'b0, 1'b1, w);
    for (int c = 0; c < 30; c++) begin
      check_eq("pulse_idle_tx", 32'(tx_o[3]), 1);
      check_eq("pulse_idle_busy", 32'(busy_o[3]), 0);
      @(negedge clk);
    end

    // Reset during data bit 3 (forced to 0 so the asynchronous rise is visible)
    d        = 9'($urandom) & ~9'h008;
    data[0]  = d;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (tx_o[0] == 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check_eq("rst_mid_start", 32'(ok), 1);
    repeat (35) @(negedge clk);
    check_eq("rst_mid_pre_tx", 32'(tx_o[0]), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_async_tx", 32'(tx_o[0]), 1);
    check_eq("rst_mid_async_busy", 32'(busy_o[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check_eq("rst_mid_after_tx", 32'(tx_o[0]), 1);
      check_eq("rst_mid_after_ready", 32'(ready_o[0]), 1);
    end

    // Random traffic across all variants
    for (int r = 0; r < 24; r++) begin
      n = int'($urandom_range(0, NI - 1));
      d = 9'($urandom);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      run_frame(n, d, 1'b0, 1'b0, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
